plugboard_store: RTL and testbench

- Responder side of the drum plugboard-access interface: a 26-entry letter-mapping store serving one drum's write requests, read requests and valid-bit vector.
- Detects contradictory plugboard hypotheses in hardware (conflict flag).
- Provides a sweep-clear between crib tests and a streaming dump port for the HPS/host readback path.
- Sits between a drum instance and the bombe top-level controller.

---
 rtl/plugboard_store.sv | 220 ++++++++++++++++++++++
 tb/tb_plugboard_store.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/plugboard_store.sv
// Plugboard letter-mapping store: 26-entry table with valid bits, conflict
// detection, sweep-clear and a streaming dump port for host readback.
module plugboard_store #(
   parameter int N_LETTERS = 26,
   parameter int W         = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear_req,
   input  logic                 dump_req,
   output logic                 busy,
   input  logic                 wr_en,
   input  logic [W-1:0]         wr_addr,
   input  logic [W-1:0]         wr_data,
   input  logic [W-1:0]         rd_addr,
   output logic [W-1:0]         rd_data,
   output logic [N_LETTERS-1:0] valid_vec,
   output logic [W-1:0]         num_mapped,
   output logic                 conflict,
   output logic [W-1:0]         conflict_addr,
   output logic                 addr_error,
   output logic                 dump_valid,
   output logic [W-1:0]         dump_addr,
   output logic [W-1:0]         dump_data,
   output logic                 dump_mapped,
   output logic                 dump_last
);

   typedef enum logic [1:0] {
      S_CLEAR = 2'd0,
      S_IDLE  = 2'd1,
      S_DUMP  = 2'd2
   } state_t;

   localparam logic [W-1:0] LAST    = W'(N_LETTERS - 1);
   localparam logic [W-1:0] NUM_MAX = W'(N_LETTERS);

   state_t                 state_q;
   logic [W-1:0]           idx_q;
   logic [W-1:0]           mem_q [0:N_LETTERS-1];
   logic [N_LETTERS-1:0]   valid_q, valid_d;
   logic [W-1:0]           num_q, num_d;
   logic                   conflict_q, conflict_d;
   logic [W-1:0]           conflict_addr_q, conflict_addr_d;
   logic                   addr_error_q, addr_error_d;
   logic                   dump_valid_q;
   logic [W-1:0]           dump_addr_q;
   logic [W-1:0]           dump_data_q;
   logic                   dump_mapped_q;
   logic                   dump_last_q;

   logic                   is_idle;
   logic                   wr_in_range;
   logic                   rd_in_range;
   logic                   clear_acc;
   logic                   wr_acc;
   logic                   wr_new;
   logic                   wr_diff;
   logic [W-1:0]           dump_next;
   logic                   mem_we;
   logic [W-1:0]           mem_waddr;
   logic [W-1:0]           mem_wdata;

   // Priority in IDLE: clear, then dump, then write.
   assign is_idle     = (state_q == S_IDLE);
   assign wr_in_range = (wr_addr < NUM_MAX);
   assign rd_in_range = (rd_addr < NUM_MAX);
   assign clear_acc   = is_idle && clear_req;
   assign wr_acc      = is_idle && !clear_req && !dump_req && wr_en;
   assign wr_new      = wr_acc && wr_in_range && !valid_q[wr_addr];
   assign wr_diff     = wr_acc && wr_in_range && valid_q[wr_addr]
                        && (mem_q[wr_addr] != wr_data);
   assign dump_next   = dump_addr_q + W'(1);

   assign busy          = (state_q != S_IDLE);
   assign rd_data       = rd_in_range ? mem_q[rd_addr] : '0;
   assign valid_vec     = valid_q;
   assign num_mapped    = num_q;
   assign conflict      = conflict_q;
   assign conflict_addr = conflict_addr_q;
   assign addr_error    = addr_error_q;
   assign dump_valid    = dump_valid_q;
   assign dump_addr     = dump_addr_q;
   assign dump_data     = dump_data_q;
   assign dump_mapped   = dump_mapped_q;
   assign dump_last     = dump_last_q;

   // Memory write port: the sweep writes zeros, a fresh mapping writes its letter.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = idx_q;
      mem_wdata = '0;
      if (reset) begin
         mem_we = 1'b0;
      end else if (state_q == S_CLEAR) begin
         mem_we = 1'b1;
      end else if (wr_new) begin
         mem_we    = 1'b1;
         mem_waddr = wr_addr;
         mem_wdata = wr_data;
      end else begin
         mem_we = 1'b0;
      end
   end

   // Table storage.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   // Next-state for valid bits, count and sticky flags.
   always_comb begin
      valid_d         = valid_q;
      num_d           = num_q;
      conflict_d      = conflict_q;
      conflict_addr_d = conflict_addr_q;
      addr_error_d    = addr_error_q;
      if (clear_acc) begin
         valid_d         = '0;
         num_d           = '0;
         conflict_d      = 1'b0;
         conflict_addr_d = '0;
         addr_error_d    = 1'b0;
      end else if (wr_new) begin
         valid_d[wr_addr] = 1'b1;
         if (num_q != NUM_MAX) begin
            num_d = num_q + W'(1);
         end else begin
            num_d = num_q;
         end
      end else if (wr_diff) begin
         conflict_d = 1'b1;
         if (!conflict_q) begin
            conflict_addr_d = wr_addr;
         end else begin
            conflict_addr_d = conflict_addr_q;
         end
      end else if (wr_acc && !wr_in_range) begin
         addr_error_d = 1'b1;
      end else begin
         addr_error_d = addr_error_q;
      end
   end

   // Valid bits, count and sticky flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q         <= '0;
         num_q           <= '0;
         conflict_q      <= 1'b0;
         conflict_addr_q <= '0;
         addr_error_q    <= 1'b0;
      end else begin
         valid_q         <= valid_d;
         num_q           <= num_d;
         conflict_q      <= conflict_d;
         conflict_addr_q <= conflict_addr_d;
         addr_error_q    <= addr_error_d;
      end
   end

   // Control FSM with registered dump beat outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_CLEAR;
         idx_q         <= '0;
         dump_valid_q  <= 1'b0;
         dump_addr_q   <= '0;
         dump_data_q   <= '0;
         dump_mapped_q <= 1'b0;
         dump_last_q   <= 1'b0;
      end else begin
         case (state_q)
            S_CLEAR: begin
               if (idx_q == LAST) begin
                  state_q <= S_IDLE;
                  idx_q   <= '0;
               end else begin
                  idx_q <= idx_q + W'(1);
               end
            end
            S_IDLE: begin
               if (clear_req) begin
                  state_q <= S_CLEAR;
                  idx_q   <= '0;
               end else if (dump_req) begin
                  state_q       <= S_DUMP;
                  dump_valid_q  <= 1'b1;
                  dump_addr_q   <= '0;
                  dump_data_q   <= mem_q[0];
                  dump_mapped_q <= valid_q[0];
                  dump_last_q   <= (LAST == '0);
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_DUMP: begin
               if (dump_addr_q == LAST) begin
                  state_q      <= S_IDLE;
                  dump_valid_q <= 1'b0;
                  dump_last_q  <= 1'b0;
               end else begin
                  dump_addr_q   <= dump_next;
                  dump_data_q   <= mem_q[dump_next];
                  dump_mapped_q <= valid_q[dump_next];
                  dump_last_q   <= (dump_next == LAST);
               end
            end
            default: begin
               state_q      <= S_CLEAR;
               idx_q        <= '0;
               dump_valid_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_plugboard_store.sv
// Randomized and directed bench for plugboard_store against a table-level model.
module tb_plugboard_store;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clear_req = 1'b0;
   logic        dump_req = 1'b0;
   logic        busy;
   logic        wr_en = 1'b0;
   logic [4:0]  wr_addr = 5'd0;
   logic [4:0]  wr_data = 5'd0;
   logic [4:0]  rd_addr = 5'd0;
   logic [4:0]  rd_data;
   logic [25:0] valid_vec;
   logic [4:0]  num_mapped;
   logic        conflict;
   logic [4:0]  conflict_addr;
   logic        addr_error;
   logic        dump_valid;
   logic [4:0]  dump_addr;
   logic [4:0]  dump_data;
   logic        dump_mapped;
   logic        dump_last;

   plugboard_store dut (
      .clk(clk), .reset(reset), .clear_req(clear_req), .dump_req(dump_req),
      .busy(busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_data), .valid_vec(valid_vec),
      .num_mapped(num_mapped), .conflict(conflict), .conflict_addr(conflict_addr),
      .addr_error(addr_error), .dump_valid(dump_valid), .dump_addr(dump_addr),
      .dump_data(dump_data), .dump_mapped(dump_mapped), .dump_last(dump_last)
   );

   always #5 clk = ~clk;

   // Reference model: the table as plain arrays plus "cycles left" counters.
   int          n_cmp = 0;
   int          n_err = 0;
   logic [4:0]  mem_m [26];
   bit          valid_m [26];
   int          num_m = 0;
   bit          conf_m = 1'b0;
   int          caddr_m = 0;
   bit          aerr_m = 1'b0;
   int          clear_left = 0;
   int          dump_beat = -1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] valid_word();
      logic [31:0] v = 32'd0;
      for (int i = 0; i < 26; i++) if (valid_m[i]) v = v | (32'd1 << i);
      return v;
   endfunction

   task automatic wipe_table();
      for (int i = 0; i < 26; i++) begin
         mem_m[i]   = 5'd0;
         valid_m[i] = 1'b0;
      end
      num_m = 0; conf_m = 1'b0; caddr_m = 0; aerr_m = 1'b0;
      clear_left = 26;
   endtask

   task automatic model_step();
      int a;
      a = int'(wr_addr);
      if (reset) begin
         wipe_table();
         dump_beat = -1;
      end else if (clear_left > 0) begin
         clear_left--;
      end else if (dump_beat >= 0) begin
         dump_beat = (dump_beat == 25) ? -1 : dump_beat + 1;
      end else if (clear_req) begin
         wipe_table();
      end else if (dump_req) begin
         dump_beat = 0;
      end else if (wr_en) begin
         if (a >= 26) aerr_m = 1'b1;
         else if (!valid_m[a]) begin
            mem_m[a] = wr_data; valid_m[a] = 1'b1;
            if (num_m < 26) num_m++;
         end else if (mem_m[a] != wr_data) begin
            if (!conf_m) caddr_m = a;
            conf_m = 1'b1;
         end
      end
   endtask

   task automatic compare_all();
      check_eq("busy", {31'd0, busy}, {31'd0, (clear_left > 0) || (dump_beat >= 0)});
      check_eq("valid_vec", {6'd0, valid_vec}, valid_word());
      check_eq("num_mapped", {27'd0, num_mapped}, num_m);
      check_eq("conflict", {31'd0, conflict}, {31'd0, conf_m});
      check_eq("conflict_addr", {27'd0, conflict_addr}, caddr_m);
      check_eq("addr_error", {31'd0, addr_error}, {31'd0, aerr_m});
      check_eq("dump_valid", {31'd0, dump_valid}, {31'd0, dump_beat >= 0});
      if (dump_beat >= 0) begin
         check_eq("dump_addr", {27'd0, dump_addr}, dump_beat);
         check_eq("dump_data", {27'd0, dump_data}, {27'd0, mem_m[dump_beat]});
         check_eq("dump_mapped", {31'd0, dump_mapped}, {31'd0, valid_m[dump_beat]});
         check_eq("dump_last", {31'd0, dump_last}, {31'd0, dump_beat == 25});
      end
      if (clear_left == 0) begin
         check_eq("rd_data", {27'd0, rd_data},
                  (int'(rd_addr) < 26) ? {27'd0, mem_m[int'(rd_addr)]} : 32'd0);
      end
   endtask

   task automatic cycle(input logic rst, input logic cr, input logic dr, input logic we,
                        input logic [4:0] wa, input logic [4:0] wd, input logic [4:0] ra);
      reset = rst; clear_req = cr; dump_req = dr; wr_en = we;
      wr_addr = wa; wr_data = wd; rd_addr = ra;
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic idle(input int n, output int busy_cnt);
      busy_cnt = 0;
      for (int i = 0; i < n; i++) begin
         cycle(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'($urandom_range(0, 31)));
         if (busy) busy_cnt++;
      end
   endtask

   task automatic wr(input logic [4:0] a, input logic [4:0] d);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, a, d, a);
   endtask

   initial begin
      int cnt;
      int extra;
      logic [4:0] wa;
      logic [4:0] wd;

      // Reset and the initial sweep.
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      check_eq("rst_dump_addr", {27'd0, dump_addr}, 32'd0);
      check_eq("rst_dump_data", {27'd0, dump_data}, 32'd0);
      check_eq("rst_dump_flags", {30'd0, dump_mapped, dump_last}, 32'd0);
      cnt = busy ? 1 : 0;
      idle(30, extra);
      check_eq("reset_busy_cycles", cnt + extra, 32'd26);
      for (int i = 0; i < 32; i++) begin
         cycle(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'(i));
         check_eq("rd_after_reset", {27'd0, rd_data}, 32'd0);
      end

      // Two independent mappings.
      wr(5'd3, 5'd17);
      wr(5'd17, 5'd3);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd3);
      check_eq("pair_valid", {6'd0, valid_vec}, (32'd1 << 3) | (32'd1 << 17));
      check_eq("pair_num", {27'd0, num_mapped}, 32'd2);
      check_eq("pair_rd3", {27'd0, rd_data}, 32'd17);
      check_eq("pair_conflict", {31'd0, conflict}, 32'd0);

      // Idempotent rewrite, then conflicts; first conflict address is kept.
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      idle(26, extra);
      wr(5'd3, 5'd17);
      wr(5'd3, 5'd17);
      wr(5'd3, 5'd9);
      check_eq("conf_num", {27'd0, num_mapped}, 32'd1);
      check_eq("conf_mem3", {27'd0, rd_data}, 32'd17);
      check_eq("conf_flag", {31'd0, conflict}, 32'd1);
      wr(5'd5, 5'd6);
      wr(5'd5, 5'd7);
      check_eq("conf_addr_kept", {27'd0, conflict_addr}, 32'd3);

      // Out-of-range write and read.
      wr(5'd30, 5'd1);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd28);
      check_eq("addr_error", {31'd0, addr_error}, 32'd1);
      check_eq("oor_valid", {6'd0, valid_vec}, (32'd1 << 3) | (32'd1 << 5));
      check_eq("oor_rd28", {27'd0, rd_data}, 32'd0);

      // Dump with a write attempted mid-dump.
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      idle(26, extra);
      wr(5'd0, 5'd25);
      wr(5'd25, 5'd0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
      for (int b = 1; b < 27; b++) begin
         cycle(1'b0, 1'b0, 1'b0, (b == 6), 5'd9, 5'd4, 5'd9);
         if (b == 25) check_eq("dump_last25", {31'd0, dump_last}, 32'd1);
      end
      check_eq("dump_done", {31'd0, dump_valid}, 32'd0);
      check_eq("dump_wr_ignored", {6'd0, valid_vec}, (32'd1 << 0) | (32'd1 << 25));

      // Clear with a concurrent write.
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 5'd7, 5'd7);
      cnt = busy ? 1 : 0;
      idle(30, extra);
      check_eq("clear_busy_cycles", cnt + extra, 32'd26);
      check_eq("clear_valid", {6'd0, valid_vec}, 32'd0);

      // Reset on dump beat 10.
      wr(5'd2, 5'd11);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
      idle(10, extra);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      check_eq("abort_dump_valid", {31'd0, dump_valid}, 32'd0);
      cnt = busy ? 1 : 0;
      idle(30, extra);
      check_eq("abort_busy_cycles", cnt + extra, 32'd26);

      // Randomized traffic.
      for (int i = 0; i < 4000; i++) begin
         wa = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(26, 31)) : 5'($urandom_range(0, 25));
         wd = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
         cycle(($urandom_range(0, 599) == 0), ($urandom_range(0, 149) == 0),
               ($urandom_range(0, 59) == 0), ($urandom_range(0, 1) == 1),
               wa, wd, 5'($urandom_range(0, 31)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
